// File: rtl/logic_unit_pipe.sv
// rtl/logic_unit_pipe.sv - two-stage pipelined bitwise logic unit with valid/ready handshakes
// Optional zero/parity result flags are enabled by defining LOGIC_FLAGS_EN.
module logic_unit_pipe #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [CNT_W-1:0] done_cnt
`ifdef LOGIC_FLAGS_EN
    ,
    output logic             flag_z,
    output logic             flag_p
`endif
);

    logic             s1_valid;
    logic [2:0]       s1_op;
    logic [WIDTH-1:0] s1_a;
    logic [WIDTH-1:0] s1_b;
    logic             s2_valid;
    logic             s2_adv;
    logic             s1_adv;
    logic             in_acc;
    logic [WIDTH-1:0] s1_res;

    // Stall rules: out_valid is purely the stage-2 register, so it never sees out_ready.
    assign s2_adv    = !s2_valid || out_ready;
    assign s1_adv    = s1_valid && s2_adv;
    assign in_ready  = !s1_valid || s2_adv;
    assign in_acc    = in_valid && in_ready;
    assign out_valid = s2_valid;

    always_comb begin
        s1_res = '0;
        case (s1_op)
            3'b000:  s1_res = s1_a & s1_b;
            3'b001:  s1_res = s1_a | s1_b;
            3'b010:  s1_res = s1_a ^ s1_b;
            3'b011:  s1_res = ~s1_a;
            3'b100:  s1_res = ~(s1_a & s1_b);
            3'b101:  s1_res = ~(s1_a | s1_b);
            3'b110:  s1_res = ~(s1_a ^ s1_b);
            default: s1_res = s1_a;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_op    <= '0;
            s1_a     <= '0;
            s1_b     <= '0;
        end else begin
            if (in_acc) begin
                s1_valid <= 1'b1;
                s1_op    <= op;
                s1_a     <= a;
                s1_b     <= b;
            end else if (s1_adv) begin
                s1_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid <= 1'b0;
            result   <= '0;
`ifdef LOGIC_FLAGS_EN
            flag_z   <= 1'b0;
            flag_p   <= 1'b0;
`endif
        end else if (s2_adv) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                result <= s1_res;
`ifdef LOGIC_FLAGS_EN
                flag_z <= (s1_res == '0);
                flag_p <= ^s1_res;
`endif
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done_cnt <= '0;
        end else if (s2_valid && out_ready) begin
            done_cnt <= done_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_logic_unit_pipe.sv
// tb/tb_logic_unit_pipe.sv - self-checking bench for logic_unit_pipe
// Define LOGIC_FLAGS_EN for both files to exercise the flag outputs.
module tb_logic_unit_pipe;

    localparam int WIDTH = 4;
    localparam int CNT_W = 8;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [2:0]       op = '0;
    logic [WIDTH-1:0] a = '0;
    logic [WIDTH-1:0] b = '0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [WIDTH-1:0] result;
    logic [CNT_W-1:0] done_cnt;
`ifdef LOGIC_FLAGS_EN
    logic             flag_z;
    logic             flag_p;
`endif

    logic_unit_pipe #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .a(a), .b(b),
        .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .done_cnt(done_cnt)
`ifdef LOGIC_FLAGS_EN
        , .flag_z(flag_z), .flag_p(flag_p)
`endif
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: low two opcode bits pick AND/OR/XOR/PASS, bit 2 inverts; NOT a is inverted PASS.
    function automatic logic [WIDTH-1:0] ref_op(input logic [2:0] o, input logic [WIDTH-1:0] x,
                                                input logic [WIDTH-1:0] y);
        logic [WIDTH-1:0] base;
        logic             inv;
        case (o)
            3'd0, 3'd4: base = x & y;
            3'd1, 3'd5: base = x | y;
            3'd2, 3'd6: base = x ^ y;
            default:    base = x;
        endcase
        inv = (o == 3'd3) || (o >= 3'd4 && o != 3'd7);
        return inv ? ~base : base;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [2:0]       op;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [WIDTH-1:0] exp;
    } vec_t;

    vec_t vecs[10];
    vec_t bp[3];
    logic [WIDTH-1:0] q[$];
    logic [WIDTH-1:0] exp_r;
    logic [WIDTH-1:0] held;
    int model_cnt;
    int base_cnt;
    int accepts;
    int got;
    logic prev_hold;
    logic [WIDTH-1:0] prev_res;
    logic acc_last;

    initial begin
        vecs[0] = '{3'b011, 4'b1001, 4'b0000, 4'b0110};
        vecs[1] = '{3'b011, 4'b0110, 4'b0000, 4'b1001};
        vecs[2] = '{3'b000, 4'b1100, 4'b1010, 4'b1000};
        vecs[3] = '{3'b001, 4'b1100, 4'b1010, 4'b1110};
        vecs[4] = '{3'b010, 4'b1100, 4'b1010, 4'b0110};
        vecs[5] = '{3'b110, 4'b1100, 4'b1010, 4'b1001};
        vecs[6] = '{3'b100, 4'b1100, 4'b1010, 4'b0111};
        vecs[7] = '{3'b101, 4'b1100, 4'b1010, 4'b0001};
        vecs[8] = '{3'b111, 4'b1100, 4'b1111, 4'b1100};
        vecs[9] = '{3'b000, 4'b0101, 4'b1010, 4'b0000};

        // Reset state
        #2;
        check("rst_out_valid", out_valid, 0);
        check("rst_result", result, 0);
        check("rst_done_cnt", done_cnt, 0);
        tick();
        rst_n = 1'b1;
        tick();
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid_after", out_valid, 0);

        // Back-to-back table: one result per cycle, two edges after presentation
        for (int i = 0; i <= 10; i++) begin
            out_ready = 1'b1;
            if (i < 10) begin
                in_valid = 1'b1;
                op = vecs[i].op; a = vecs[i].a; b = vecs[i].b;
            end else begin
                in_valid = 1'b0;
            end
            #1;
            check("tbl_in_ready", in_ready, 1);
            tick();
            check("tbl_out_valid", out_valid, (i >= 1) ? 1 : 0);
            if (i >= 1) begin
                check("tbl_result", result, vecs[i-1].exp);
`ifdef LOGIC_FLAGS_EN
                check("tbl_flag_z", flag_z, (vecs[i-1].exp == 0) ? 1 : 0);
                check("tbl_flag_p", flag_p, ^vecs[i-1].exp);
`endif
            end
        end
        tick();
        check("tbl_idle", out_valid, 0);
        check("tbl_done_cnt", done_cnt, 10);
        base_cnt = 10;

        // Backpressure: 3 beats offered, out_ready low for 5 cycles
        bp[0] = '{3'b000, 4'b1100, 4'b1010, 4'b1000};
        bp[1] = '{3'b001, 4'b1100, 4'b1010, 4'b1110};
        bp[2] = '{3'b010, 4'b1100, 4'b1010, 4'b0110};
        accepts = 0;
        out_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            in_valid = (accepts < 3);
            op = bp[accepts % 3].op; a = bp[accepts % 3].a; b = bp[accepts % 3].b;
            #1;
            if (in_valid && in_ready) accepts++;
            tick();
            if (c >= 2) begin
                check("bp_hold_valid", out_valid, 1);
                check("bp_hold_result", result, bp[0].exp);
            end
        end
        check("bp_accepts", accepts, 2);
        check("bp_in_ready_low", in_ready, 0);
        out_ready = 1'b1;
        got = 0;
        for (int c = 0; c < 20 && got < 3; c++) begin
            in_valid = (accepts < 3);
            op = bp[2].op; a = bp[2].a; b = bp[2].b;
            #1;
            if (out_valid && out_ready) begin
                check("bp_order", result, bp[got].exp);
                got++;
            end
            if (in_valid && in_ready) accepts++;
            tick();
        end
        in_valid = 1'b0;
        check("bp_got_all", got, 3);
        check("bp_done_cnt", done_cnt, base_cnt + 3);

        // Reset with two beats in flight
        out_ready = 1'b0;
        for (int c = 0; c < 2; c++) begin
            in_valid = 1'b1; op = 3'b111; a = 4'b1111; b = 4'b0000;
            tick();
        end
        in_valid = 1'b0;
        check("rstmid_pre_valid", out_valid, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("rstmid_out_valid", out_valid, 0);
        check("rstmid_done_cnt", done_cnt, 0);
        tick();
        rst_n = 1'b1;
        out_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            tick();
            check("rstmid_no_stale", out_valid, 0);
        end

        // Randomized traffic against the reference queue; long enough to wrap done_cnt
        model_cnt = 0;
        prev_hold = 1'b0;
        acc_last = 1'b1;
        for (int c = 0; c < 700; c++) begin
            check("rnd_done_cnt", done_cnt, model_cnt % (1 << CNT_W));
            if (prev_hold) begin
                check("rnd_hold_valid", out_valid, 1);
                check("rnd_hold_result", result, prev_res);
            end
            if (!in_valid || acc_last) begin
                in_valid = ($urandom_range(0, 3) != 0);
                op = 3'($urandom_range(0, 7));
                a = WIDTH'($urandom);
                b = WIDTH'($urandom);
            end
            out_ready = ($urandom_range(0, 3) != 0);
            #1;
            acc_last = in_valid && in_ready;
            if (acc_last) q.push_back(ref_op(op, a, b));
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    check("rnd_spurious", 1, 0);
                end else begin
                    exp_r = q.pop_front();
                    check("rnd_result", result, exp_r);
`ifdef LOGIC_FLAGS_EN
                    check("rnd_flag_z", flag_z, (exp_r == 0) ? 1 : 0);
                    check("rnd_flag_p", flag_p, ^exp_r);
`endif
                end
                model_cnt++;
            end
            prev_hold = out_valid && !out_ready;
            prev_res = result;
            tick();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int c = 0; c < 10 && q.size() > 0; c++) begin
            #1;
            if (out_valid) begin
                exp_r = q.pop_front();
                check("drain_result", result, exp_r);
                model_cnt++;
            end
            tick();
        end
        check("drain_empty", q.size(), 0);
        check("drain_done_cnt", done_cnt, model_cnt % (1 << CNT_W));
        check("wrap_exercised", (model_cnt >= (1 << CNT_W)) ? 1 : 0, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1);
    end

endmodule
